// File: rtl/digit_string_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_string_renderer_if
// Brief    : Digit load/commit and pixel-stream signals of the readout renderer.
// Revision : 1.0
// ============================================================================
interface digit_string_renderer_if #(
  parameter int NUM_DIGITS = 9,
  parameter int XW         = 11,
  parameter int YW         = 10
);
  logic                    frame_start;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    digits_load;
  logic                    lz_blank;
  logic                    pix_valid;
  logic [XW-1:0]           pix_x;
  logic [YW-1:0]           pix_y;
  logic                    pix_on;
  logic                    pix_on_valid;
  logic                    load_pending;

  modport master (
    output frame_start, digits_in, digits_load, lz_blank, pix_valid, pix_x, pix_y,
    input  pix_on, pix_on_valid, load_pending
  );

  modport slave (
    input  frame_start, digits_in, digits_load, lz_blank, pix_valid, pix_x, pix_y,
    output pix_on, pix_on_valid, load_pending
  );
endinterface
`default_nettype wire

// File: rtl/digit_string_renderer.sv
`default_nettype none
// ============================================================================
// Module   : digit_string_renderer
// Brief    : Double-buffered BCD string to 2-stage registered glyph pixel bit.
// Revision : 1.0
// ============================================================================
module digit_string_renderer #(
  parameter int NUM_DIGITS = 9,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int SCALE_LOG2 = 0,
  parameter int XW         = 11,
  parameter int YW         = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  digit_string_renderer_if.slave  bus
);
  localparam int c_dw   = ((XW > YW) ? XW : YW) + 1;
  localparam int c_xlen = (NUM_DIGITS * 16) << SCALE_LOG2;
  localparam int c_ylen = 16 << SCALE_LOG2;
  localparam logic [3:0] c_code_blank = 4'd10;

  logic [4*NUM_DIGITS-1:0] r_staging;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_pending;

  logic [4*NUM_DIGITS-1:0] w_src;
  logic [NUM_DIGITS-1:0]   w_mask;
  logic                    w_allz;

  logic [c_dw-1:0] w_dx, w_dy, w_dxs;
  logic            w_inreg;
  logic [3:0]      w_code;

  logic       r_s1_valid, r_s1_inreg;
  logic [3:0] r_s1_code, r_s1_row, r_s1_col;
  logic       r_pix_on, r_pix_on_valid;
  logic [15:0] w_word;
  logic        w_bit;

  // Segment-style font: a=top, b/f=upper sides, c/e=lower sides, d=bottom, g=middle (row 7).
  function automatic logic [15:0] font_row(input logic [3:0] code, input logic [3:0] row);
    logic [6:0]  seg;
    logic [15:0] up, lo, word;
    seg = 7'b0;
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0;
    endcase
    up = (seg[1] ? 16'h4000 : 16'h0) | (seg[5] ? 16'h0002 : 16'h0);
    lo = (seg[2] ? 16'h4000 : 16'h0) | (seg[4] ? 16'h0002 : 16'h0);
    if (row == 4'd0)       word = seg[6] ? 16'h7FFE : up;
    else if (row < 4'd7)   word = up;
    else if (row == 4'd7)  word = seg[0] ? 16'h7FFE : up;
    else if (row < 4'd15)  word = lo;
    else                   word = seg[3] ? 16'h7FFE : lo;
    if (code == 4'd1)
      word = 16'h0180;
    else if (code == 4'd11)
      word = (row == 4'd7 || row == 4'd8) ? 16'h3FFC : 16'h0000;
    return word;
  endfunction

  // Blank mask for whatever is about to be committed; a same-cycle load bypasses staging.
  always_comb begin
    w_src  = bus.digits_load ? bus.digits_in : r_staging;
    w_mask = '0;
    w_allz = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_allz    = w_allz & (w_src[4*k +: 4] == 4'd0);
      w_mask[k] = bus.lz_blank & w_allz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_staging <= '0;
      r_active  <= {NUM_DIGITS{c_code_blank}};
      r_blank   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus.frame_start && (bus.digits_load || r_pending)) begin
        r_active  <= w_src;
        r_blank   <= w_mask;
        r_pending <= 1'b0;
      end
      if (bus.digits_load) begin
        r_staging <= bus.digits_in;
        if (!bus.frame_start)
          r_pending <= 1'b1;
      end
    end
  end

  // Geometry: unsigned subtraction in a widened field; a set MSB means left/above the string.
  always_comb begin
    w_dx    = c_dw'(bus.pix_x) - c_dw'(X0);
    w_dy    = c_dw'(bus.pix_y) - c_dw'(Y0);
    w_dxs   = w_dx >> (4 + SCALE_LOG2);
    w_inreg = !w_dx[c_dw-1] && !w_dy[c_dw-1] &&
              (w_dx < c_dw'(c_xlen)) && (w_dy < c_dw'(c_ylen));
    w_code  = c_code_blank;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_inreg && (w_dxs == c_dw'(NUM_DIGITS - 1 - k)) && !r_blank[k])
        w_code = r_active[4*k +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_inreg <= 1'b0;
      r_s1_code  <= c_code_blank;
      r_s1_row   <= 4'd0;
      r_s1_col   <= 4'd0;
    end else begin
      r_s1_valid <= bus.pix_valid;
      r_s1_inreg <= w_inreg;
      r_s1_code  <= w_code;
      r_s1_row   <= w_dy[SCALE_LOG2 +: 4];
      r_s1_col   <= w_dx[SCALE_LOG2 +: 4];
    end
  end

  always_comb begin
    w_word = font_row(r_s1_code, r_s1_row);
    w_bit  = w_word[4'd15 - r_s1_col];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_on       <= 1'b0;
      r_pix_on_valid <= 1'b0;
    end else begin
      r_pix_on       <= r_s1_valid & r_s1_inreg & w_bit;
      r_pix_on_valid <= r_s1_valid;
    end
  end

  assign bus.pix_on       = r_pix_on;
  assign bus.pix_on_valid = r_pix_on_valid;
  assign bus.load_pending = r_pending;
endmodule
`default_nettype wire

// File: tb/tb_digit_string_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_string_renderer
// Brief    : Directed checks of load/commit, blanking, glyphs and scaling.
// Revision : 1.0
// ============================================================================
module tb_digit_string_renderer;
  localparam int A_X0 = 16;
  localparam int A_Y0 = 8;
  localparam int B_X0 = 20;
  localparam int B_Y0 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, digits_load, lz_blank, pix_valid;
  logic [35:0] digits_in;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  int ncmp  = 0;
  int nfail = 0;
  int lit[16];
  int vbad;
  int total;

  always #5 clk = ~clk;

  digit_string_renderer_if #(.NUM_DIGITS(9), .XW(11), .YW(10)) if0 ();
  digit_string_renderer_if #(.NUM_DIGITS(9), .XW(11), .YW(10)) if1 ();

  assign if0.frame_start = frame_start;  assign if1.frame_start = frame_start;
  assign if0.digits_in   = digits_in;    assign if1.digits_in   = digits_in;
  assign if0.digits_load = digits_load;  assign if1.digits_load = digits_load;
  assign if0.lz_blank    = lz_blank;     assign if1.lz_blank    = lz_blank;
  assign if0.pix_valid   = pix_valid;    assign if1.pix_valid   = pix_valid;
  assign if0.pix_x       = pix_x;        assign if1.pix_x       = pix_x;
  assign if0.pix_y       = pix_y;        assign if1.pix_y       = pix_y;

  digit_string_renderer #(.NUM_DIGITS(9), .X0(A_X0), .Y0(A_Y0), .SCALE_LOG2(0), .XW(11), .YW(10))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  digit_string_renderer #(.NUM_DIGITS(9), .X0(B_X0), .Y0(B_Y0), .SCALE_LOG2(1), .XW(11), .YW(10))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input int x, input int y, input bit use1, input logic exp);
    @(negedge clk);
    pix_x = 11'(x); pix_y = 10'(y); pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    check({tag, ".on"},  use1 ? if1.pix_on : if0.pix_on, exp);
    check({tag, ".vld"}, use1 ? if1.pix_on_valid : if0.pix_on_valid, 1);
  endtask

  task automatic load(input logic [35:0] val, input logic lz);
    @(negedge clk);
    digits_in = val; lz_blank = lz; digits_load = 1'b1;
    @(negedge clk);
    digits_load = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Streams the whole dut0 string region; output at each negedge belongs to the pixel driven two negedges earlier.
  task automatic scan0();
    bit qv[$];
    int qx[$];
    bit v;
    int xx;
    foreach (lit[i]) lit[i] = 0;
    vbad = 0;
    for (int n = 0; n < 144*16 + 2; n++) begin
      @(negedge clk);
      if (qv.size() == 2) begin
        v  = qv.pop_front();
        xx = qx.pop_front();
        if (if0.pix_on_valid !== v) vbad++;
        if (if0.pix_on === 1'b1) begin
          if (!v) vbad++;
          else    lit[xx/16]++;
        end
      end
      if (n < 144*16) begin
        pix_x = 11'(A_X0 + n % 144); pix_y = 10'(A_Y0 + n / 144); pix_valid = 1'b1;
        qv.push_back(1'b1); qx.push_back(n % 144);
      end else begin
        pix_valid = 1'b0;
        qv.push_back(1'b0); qx.push_back(0);
      end
    end
    total = 0;
    foreach (lit[i]) total += lit[i];
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; digits_load = 1'b0; lz_blank = 1'b0;
    pix_valid = 1'b0; digits_in = '0; pix_x = '0; pix_y = '0;
    repeat (2) @(negedge clk);
    check("rst.pix_on", if0.pix_on, 0);
    check("rst.pix_on_valid", if0.pix_on_valid, 0);
    check("rst.load_pending", if0.load_pending, 0);
    rst = 1'b0;

    // Dark after reset.
    scan0();
    check("dark.lit_total", total, 0);
    check("dark.valid_align", vbad, 0);

    // "000001230" with leading-zero blanking.
    load(36'h000001230, 1'b1);
    check("load1.pending", if0.load_pending, 1);
    commit();
    check("commit1.pending", if0.load_pending, 0);
    scan0();
    check("lz.slots0_4", lit[0] + lit[1] + lit[2] + lit[3] + lit[4], 0);
    check("lz.slot5_one", lit[5], 32);
    check("lz.slot8_zero", lit[8], 56);
    check("lz.valid_align", vbad, 0);
    probe("one_col7", A_X0 + 5*16 + 7, A_Y0, 1'b0, 1'b1);
    probe("zero_r1c1", A_X0 + 8*16 + 1, A_Y0 + 1, 1'b0, 1'b1);

    // Double buffering: A="...1" shown while B="...0" waits.
    load(36'h000000001, 1'b1);
    commit();
    check("commitA.pending", if0.load_pending, 0);
    load(36'h000000000, 1'b1);
    check("stageB.pending", if0.load_pending, 1);
    probe("A_held_r0c1", A_X0 + 8*16 + 1, A_Y0, 1'b0, 1'b0);
    probe("A_held_r0c7", A_X0 + 8*16 + 7, A_Y0, 1'b0, 1'b1);
    check("stageB.still_pending", if0.load_pending, 1);
    commit();
    check("commitB.pending", if0.load_pending, 0);
    probe("B_shown_r0c1", A_X0 + 8*16 + 1, A_Y0, 1'b0, 1'b1);

    // Simultaneous load and frame_start, blanking off.
    @(negedge clk);
    digits_in = 36'h000000008; lz_blank = 1'b0; digits_load = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    digits_load = 1'b0; frame_start = 1'b0;
    check("direct.pending", if0.load_pending, 0);
    probe("eight_r7c1", A_X0 + 8*16 + 1, A_Y0 + 7, 1'b0, 1'b1);
    probe("eight_r7c5", A_X0 + 8*16 + 5, A_Y0 + 7, 1'b0, 1'b1);
    probe("eight_r3c8", A_X0 + 8*16 + 8, A_Y0 + 3, 1'b0, 1'b0);
    probe("nolz_slot0", A_X0 + 1, A_Y0, 1'b0, 1'b1);

    // Scaled '1' in slot 0 of dut1.
    load(36'h100000000, 1'b1);
    commit();
    probe("x2_dx13", B_X0 + 13, B_Y0, 1'b1, 1'b0);
    probe("x2_dx14", B_X0 + 14, B_Y0, 1'b1, 1'b1);
    probe("x2_dx15", B_X0 + 15, B_Y0, 1'b1, 1'b1);
    probe("x2_dx16", B_X0 + 16, B_Y0, 1'b1, 1'b1);
    probe("x2_dx17", B_X0 + 17, B_Y0, 1'b1, 1'b1);
    probe("x2_dx18", B_X0 + 18, B_Y0, 1'b1, 1'b0);
    probe("x2_left_edge", B_X0 - 1, B_Y0, 1'b1, 1'b0);
    probe("x2_right_edge", B_X0 + 9*32, B_Y0 + 1, 1'b1, 1'b0);
    probe("x2_last_row", B_X0 + 14, B_Y0 + 31, 1'b1, 1'b1);
    probe("x2_below", B_X0 + 14, B_Y0 + 32, 1'b1, 1'b0);

    // Reset with pixels in flight and a pending load.
    load(36'h888888888, 1'b1);
    check("prerst.pending", if0.load_pending, 1);
    @(negedge clk);
    pix_x = 11'(A_X0 + 7); pix_y = 10'(A_Y0); pix_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("prerst.inflight_on", if0.pix_on, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.pix_on", if0.pix_on, 0);
    check("midrst.pix_on_valid", if0.pix_on_valid, 0);
    check("midrst.pending", if0.load_pending, 0);
    rst = 1'b0; pix_valid = 1'b0;
    commit();
    check("postrst.pending", if0.load_pending, 0);
    scan0();
    check("postrst.lit_total", total, 0);
    check("postrst.valid_align", vbad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/digit_string_renderer.md
# digit_string_renderer

Pixel-stream renderer for a row of NUM_DIGITS 16x16 glyphs in the oscilloscope readout overlay. It takes BCD digit codes from the measurement path and double-buffers them so a value change never tears mid-frame. It blanks leading zeros and optionally scales glyphs. For each incoming (pix_x, pix_y) it returns a registered on/off pixel bit for the overlay mixer.

## Interface
- NUM_DIGITS, 9, glyph slots in the string (1..16)
- X0, 0, left pixel column of the string
- Y0, 0, top pixel row of the string
- SCALE_LOG2, 0, glyph magnification 2^SCALE_LOG2 in x and y (0..2)
- XW, 11, pix_x width
- YW, 10, pix_y width
- clk  in  1  pixel clock; one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of frame (vertical blank)
- digits_in  in  4*NUM_DIGITS  digit codes; digit k at [4k+3:4k], k=0 rightmost (least significant)
- digits_load  in  1  request to capture digits_in
- lz_blank  in  1  leading-zero blanking enable
- pix_valid  in  1  pix_x/pix_y qualify an active pixel
- pix_x  in  XW  pixel column
- pix_y  in  YW  pixel row
- pix_on  out  1  glyph pixel lit
- pix_on_valid  out  1  pix_valid delayed 2 cycles
- load_pending  out  1  staged value waiting for next frame_start

## Operation
- Codes: 0-9 are digit glyphs from the team 16x16 digit font. 10 is blank. 11 is minus: rows 7-8 = 0x3FFC, other rows 0. Codes 12-15 are blank.
- Font bits checked by the bench:
  - '0': row0 = row15 = 0x7FFE; rows 1-14 = 0x4002.
  - '1': all rows 0x0180.
  - '8': rows 0, 7, 15 = 0x7FFE; others 0x4002.
- Column c of a row word is bit 15-c. Column 0 is the leftmost column (MSB).
- Staging register:
  - digits_load=1 samples digits_in into staging and sets load_pending.
  - Repeated loads before a commit overwrite staging; the last one wins.
- Commit:
  - frame_start with load_pending=1 copies staging into the active register, latches lz_blank, and clears load_pending.
  - If digits_load and frame_start are high in the same cycle, digits_in is committed directly and load_pending ends at 0.
  - frame_start with no pending load leaves the active register unchanged.
- Blank mask (computed at commit, registered with the active digits):
  - Digit k, for k ≥ 1, is blanked when latched lz_blank=1 and active digits k..NUM_DIGITS-1 are all code 0.
  - Digit 0 is never blanked.
- Geometry, with S = 2^SCALE_LOG2:
  - Region: X0 ≤ x < X0+NUM_DIGITS·16·S and Y0 ≤ y < Y0+16·S.
  - slot = (x-X0) >> (4+SCALE_LOG2); digit k = NUM_DIGITS-1-slot.
  - col = ((x-X0) >> SCALE_LOG2) mod 16; row = ((y-Y0) >> SCALE_LOG2) mod 16.
  - Subtractions are unsigned in max(XW,YW)+1 bits; a negative result means outside the region.
- pix_on = pix_valid & in_region & ~blank[k] & font[code_k][row][15-col].
- The active register changes only at commit, so one frame renders one coherent value.

## Timing
- Pipeline stage 1 registers: valid, in_region, selected code (forced to 10 if blanked or outside the region), row, col.
- Pipeline stage 2 registers the ROM row-word bit selection into pix_on and pix_on_valid.
- Latency is exactly 2 cycles from pix_x/pix_y/pix_valid to pix_on/pix_on_valid. Throughput is 1 pixel/cycle with no stalls.
- pix_on is 0 whenever pix_on_valid is 0.
- A commit at cycle t affects pixels presented at t+1 and later. Pixels already in the pipeline use the previous value.
- Reset values:
  - pix_on = 0, pix_on_valid = 0, load_pending = 0.
  - Staging register = all 0.
  - Active digits all code 10 (blank); blank mask = 0.
  - After reset the string renders dark until the first commit.
- Reset mid-operation flushes both pipeline stages; outputs are 0 in the cycle after rst is sampled high. A pending load is discarded.
- rst has priority over simultaneous digits_load or frame_start.

## Test plan
- Reset, then scan the full region with NUM_DIGITS=9, SCALE_LOG2=0 -> pix_on=0 everywhere; pix_on_valid follows pix_valid by 2 cycles.
- Load digits "000001230" with lz_blank=1, pulse frame_start, scan the region:
  - slots 0-4 dark;
  - slot 5 at (X0+5·16+7, Y0) -> '1' bit = 1;
  - slot 8, row 1, col 1 -> '0' bit = 1.
- Load value A, commit, load B without frame_start, rescan -> A still shown and load_pending=1. Pulse frame_start -> B shown and load_pending=0.
- Assert digits_load and frame_start in the same cycle with "000000008" -> load_pending stays 0. Row 7, col 1 of slot 8 -> pix_on=1; row 3, col 8 -> pix_on=0.
- SCALE_LOG2=1, digit '1':
  - pixels x-X0 = 14..17 within slot 0 -> on for glyph cols 7-8 only (x-X0 = 14..17);
  - x = X0-1 -> off;
  - x = X0+NUM_DIGITS·32 -> off.
- Assert rst with valid pixels in flight and a load pending -> pix_on=0, pix_on_valid=0, and load_pending=0 next cycle. A subsequent frame_start commits nothing and the string stays dark.
